// File: rtl/tlb_op_unit.sv
// TLB maintenance initiator: runs TLBR/TLBWI/TLBWR/TLBP against the MMU port,
// owns the CP0 Random counter and returns results for CP0 write-back.
package tlb_op_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

module tlb_op_unit
  import tlb_op_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int INDEX_WIDTH = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_type,
  input  logic [INDEX_WIDTH-1:0] cp0_index,
  input  logic [31:0]            cp0_entry_hi,
  input  logic [31:0]            cp0_entry_lo0,
  input  logic [31:0]            cp0_entry_lo1,
  input  logic [INDEX_WIDTH-1:0] wired,
  input  logic                   wired_we,
  output logic [INDEX_WIDTH-1:0] tlbrw_index,
  output logic                   tlbrw_we,
  output tlb_entry_t             tlbrw_wdata,
  input  tlb_entry_t             tlbrw_rdata,
  output logic [31:0]            tlbp_entry_hi,
  input  logic [31:0]            tlbp_index,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_type,
  output logic [31:0]            resp_index,
  output tlb_entry_t             resp_entry,
  output logic [INDEX_WIDTH-1:0] random
);

  localparam logic [INDEX_WIDTH-1:0] RAND_TOP = INDEX_WIDTH'(TLB_ENTRIES - 1);
  localparam logic [1:0] OP_TLBR  = 2'd0;
  localparam logic [1:0] OP_TLBWI = 2'd1;
  localparam logic [1:0] OP_TLBWR = 2'd2;
  localparam logic [1:0] OP_TLBP  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state_r;
  logic [1:0] op_type_r;

  // EntryHi[12:8], EntryLo[31:26] and the upper probe-index bits carry nothing we use.
  logic unused_bits_s;
  assign unused_bits_s = &{1'b0, cp0_entry_hi[12:8], cp0_entry_lo0[31:26],
                           cp0_entry_lo1[31:26], tlbp_index[30:INDEX_WIDTH]};

  function automatic tlb_entry_t pack_entry(input logic [18:0] vpn2,
                                            input logic [7:0]  asid,
                                            input logic [25:0] lo0,
                                            input logic [25:0] lo1);
    tlb_entry_t e;
    e.vpn2 = vpn2;
    e.asid = asid;
    e.g    = lo0[0] & lo1[0];
    e.pfn0 = lo0[25:6];
    e.c0   = lo0[5:3];
    e.d0   = lo0[2];
    e.v0   = lo0[1];
    e.pfn1 = lo1[25:6];
    e.c1   = lo1[5:3];
    e.d1   = lo1[2];
    e.v1   = lo1[1];
    return e;
  endfunction

  // Random counter: free-running down-count over [wired, TLB_ENTRIES-1].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random <= RAND_TOP;
    end else if (wired_we) begin
      random <= RAND_TOP;
    end else if ((random <= wired) || (wired >= RAND_TOP)) begin
      random <= RAND_TOP;
    end else begin
      random <= random - 1'b1;
    end
  end

  // Operation FSM; MMU-facing and response outputs are all registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      op_type_r     <= 2'd0;
      op_ready      <= 1'b1;
      resp_valid    <= 1'b0;
      tlbrw_we      <= 1'b0;
      tlbrw_index   <= '0;
      tlbrw_wdata   <= '0;
      tlbp_entry_hi <= 32'd0;
      resp_type     <= 2'd0;
      resp_index    <= 32'd0;
      resp_entry    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (op_valid) begin
            // Latching straight into the MMU registers makes them the held copy of the request.
            op_type_r     <= op_type;
            op_ready      <= 1'b0;
            tlbrw_index   <= (op_type == OP_TLBWR) ? random : cp0_index;
            tlbrw_we      <= (op_type == OP_TLBWI) || (op_type == OP_TLBWR);
            tlbrw_wdata   <= pack_entry(cp0_entry_hi[31:13], cp0_entry_hi[7:0],
                                        cp0_entry_lo0[25:0], cp0_entry_lo1[25:0]);
            tlbp_entry_hi <= cp0_entry_hi;
            state_r       <= EXEC;
          end
        end
        EXEC: begin
          tlbrw_we   <= 1'b0;
          resp_valid <= 1'b1;
          resp_type  <= op_type_r;
          if (op_type_r == OP_TLBR) begin
            resp_entry <= tlbrw_rdata;
          end
          if (op_type_r == OP_TLBP) begin
            resp_index <= {tlbp_index[31], {(31-INDEX_WIDTH){1'b0}},
                           tlbp_index[INDEX_WIDTH-1:0]};
          end
          state_r <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_ready   <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          op_ready   <= 1'b1;
          resp_valid <= 1'b0;
          tlbrw_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit: MMU environment, transaction-level model
// compared every cycle, plus hand-computed literal checks.
module tb_tlb_op_unit;
  import tlb_op_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [1:0]    op_type = 2'd0;
  logic [IW-1:0] cp0_index = '0;
  logic [31:0]   cp0_entry_hi = 32'd0;
  logic [31:0]   cp0_entry_lo0 = 32'd0;
  logic [31:0]   cp0_entry_lo1 = 32'd0;
  logic [IW-1:0] wired = '0;
  logic          wired_we = 1'b0;
  logic [IW-1:0] tlbrw_index;
  logic          tlbrw_we;
  tlb_entry_t    tlbrw_wdata;
  tlb_entry_t    tlbrw_rdata;
  logic [31:0]   tlbp_entry_hi;
  logic [31:0]   tlbp_index;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1:0]    resp_type;
  logic [31:0]   resp_index;
  tlb_entry_t    resp_entry;
  logic [IW-1:0] random;

  int n_vec = 0;
  int n_err = 0;

  tlb_op_unit #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi), .cp0_entry_lo0(cp0_entry_lo0),
    .cp0_entry_lo1(cp0_entry_lo1), .wired(wired), .wired_we(wired_we),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
    .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_type(resp_type),
    .resp_index(resp_index), .resp_entry(resp_entry), .random(random)
  );

  always #5 clk = ~clk;

  function automatic bit entry_match(input tlb_entry_t e, input logic [31:0] hi);
    return (e.vpn2 == hi[31:13]) && (e.g || (e.asid == hi[7:0]));
  endfunction

  // MMU environment: synchronous write, combinational read and probe.
  tlb_entry_t mmu_tlb [N];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mmu_tlb[i] <= '0;
    end else if (tlbrw_we) begin
      mmu_tlb[tlbrw_index] <= tlbrw_wdata;
    end
  end
  assign tlbrw_rdata = mmu_tlb[tlbrw_index];
  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--)
      if (entry_match(mmu_tlb[i], tlbp_entry_hi)) tlbp_index = 32'(i);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  tlb_entry_t  m_tlb [N];
  bit          m_busy;
  int          m_cyc;
  int          m_random;
  int          m_op;
  bit          m_write;
  int          m_widx;
  int          m_cpidx;
  logic [31:0] m_hi;
  tlb_entry_t  m_wentry;
  tlb_entry_t  m_rentry;
  logic [31:0] m_pidx;

  function automatic tlb_entry_t model_pack(input logic [31:0] hi, input logic [31:0] lo0,
                                            input logic [31:0] lo1);
    tlb_entry_t e;
    e.vpn2 = hi[31:13];  e.asid = hi[7:0];  e.g = lo0[0] & lo1[0];
    e.pfn0 = lo0[25:6];  e.c0 = lo0[5:3];   e.d0 = lo0[2];  e.v0 = lo0[1];
    e.pfn1 = lo1[25:6];  e.c1 = lo1[5:3];   e.d1 = lo1[2];  e.v1 = lo1[1];
    return e;
  endfunction

  function automatic logic [31:0] model_probe(input logic [31:0] hi);
    for (int i = 0; i < N; i++)
      if (entry_match(m_tlb[i], hi)) return 32'(i);
    return 32'h8000_0000;
  endfunction

  // Model update on each rising edge, comparison on the following falling edge.
  initial begin : model_compare
    int rn;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_busy = 1'b0;  m_cyc = 0;  m_random = N - 1;
        for (int i = 0; i < N; i++) m_tlb[i] = '0;
      end else begin
        if (wired_we) rn = N - 1;
        else if (m_random <= int'(wired) || int'(wired) >= N - 1) rn = N - 1;
        else rn = m_random - 1;
        if (m_busy) begin
          if (m_cyc == 1 && m_write) m_tlb[m_widx] = m_wentry;
          if (m_cyc >= 2 && resp_ready) m_busy = 1'b0;
          else m_cyc++;
        end else if (op_valid) begin
          m_busy   = 1'b1;
          m_cyc    = 1;
          m_op     = int'(op_type);
          m_write  = (op_type == 2'd1) || (op_type == 2'd2);
          m_widx   = (op_type == 2'd2) ? m_random : int'(cp0_index);
          m_cpidx  = int'(cp0_index);
          m_hi     = cp0_entry_hi;
          m_wentry = model_pack(cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1);
          m_rentry = m_tlb[cp0_index];
          m_pidx   = model_probe(cp0_entry_hi);
        end
        m_random = rn;
      end
      @(negedge clk);
      chk("random", 128'(random), 128'(m_random));
      chk("op_ready", 128'(op_ready), 128'(!m_busy));
      chk("resp_valid", 128'(resp_valid), 128'(m_busy && m_cyc >= 2));
      chk("tlbrw_we", 128'(tlbrw_we), 128'(m_busy && m_cyc == 1 && m_write));
      if (m_busy && m_cyc == 1) begin
        if (m_write) begin
          chk("wr_index", 128'(tlbrw_index), 128'(m_widx));
          chk("wr_data", 128'(tlbrw_wdata), 128'(m_wentry));
        end else if (m_op == 0) begin
          chk("rd_index", 128'(tlbrw_index), 128'(m_cpidx));
        end else begin
          chk("probe_hi", 128'(tlbp_entry_hi), 128'(m_hi));
        end
      end
      if (m_busy && m_cyc >= 2) begin
        chk("resp_type", 128'(resp_type), 128'(m_op));
        if (m_op == 0) chk("resp_entry", 128'(resp_entry), 128'(m_rentry));
        if (m_op == 3) chk("resp_index", 128'(resp_index), 128'(m_pidx));
      end
    end
  end

  // Called on a falling edge; returns on the falling edge of the EXEC cycle.
  task automatic start_op(input logic [1:0] t);
    int k = 0;
    while (!op_ready && k < 20) begin @(negedge clk); k++; end
    chk("op_ready_wait", 128'(op_ready), 128'(1));
    op_valid = 1'b1;
    op_type  = t;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic finish_op();
    int k = 0;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    chk("resp_valid_wait", 128'(resp_valid), 128'(1));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin : stimulus
    tlb_entry_t lit;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_random", 128'(random), 128'(15));
    chk("rst_op_ready", 128'(op_ready), 128'(1));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_tlbrw_we", 128'(tlbrw_we), 128'(0));
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("countdown", 128'(random), 128'((i <= 15) ? 15 - i : 15));
      @(negedge clk);
    end

    // TLBWI index 5: lo0 G=1, lo1 G=0 -> packed G=0.
    cp0_index     = 4'd5;
    cp0_entry_hi  = 32'h1234_60A5;
    cp0_entry_lo0 = (32'hABC << 6) | (32'd3 << 3) | 32'h4 | 32'h2 | 32'h1;
    cp0_entry_lo1 = (32'hDEF << 6) | (32'd2 << 3) | 32'h2;
    lit = '{vpn2: 19'h091A3, asid: 8'hA5, g: 1'b0,
            pfn0: 20'hABC, c0: 3'd3, d0: 1'b1, v0: 1'b1,
            pfn1: 20'hDEF, c1: 3'd2, d1: 1'b0, v1: 1'b1};
    start_op(2'd1);
    chk("wi_we", 128'(tlbrw_we), 128'(1));
    chk("wi_index", 128'(tlbrw_index), 128'(5));
    chk("wi_g", 128'(tlbrw_wdata.g), 128'(0));
    chk("wi_entry", 128'(tlbrw_wdata), 128'(lit));
    @(negedge clk);
    chk("wi_we_drop", 128'(tlbrw_we), 128'(0));
    chk("wi_resp_type", 128'(resp_type), 128'(1));
    finish_op();

    // TLBR index 5 with resp_ready held low for three cycles.
    cp0_entry_hi = 32'd0;
    start_op(2'd0);
    chk("tlbr_we", 128'(tlbrw_we), 128'(0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("tlbr_hold_valid", 128'(resp_valid), 128'(1));
      chk("tlbr_hold_entry", 128'(resp_entry), 128'(lit));
      @(negedge clk);
    end
    finish_op();

    // TLBP hit on entry 5, then a miss on a different ASID.
    cp0_entry_hi = 32'h1234_60A5;
    start_op(2'd3);
    @(negedge clk);
    chk("tlbp_hit", 128'(resp_index), 128'(32'h0000_0005));
    finish_op();
    cp0_entry_hi = 32'h1234_605A;
    start_op(2'd3);
    @(negedge clk);
    chk("tlbp_miss", 128'(resp_index[31]), 128'(1));
    finish_op();

    // Wired = 8, then TLBWR while random is 9.
    wired = 4'd8;
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    chk("wired_reload", 128'(random), 128'(15));
    k = 0;
    while (random != 4'd9 && k < 20) begin @(negedge clk); k++; end
    chk("random_reach_9", 128'(random), 128'(9));
    cp0_index = 4'd2;
    start_op(2'd2);
    chk("wr_we", 128'(tlbrw_we), 128'(1));
    chk("wr_random_index", 128'(tlbrw_index), 128'(9));
    finish_op();
    for (int i = 0; i < 20; i++) begin
      chk("random_ge_wired", 128'(random >= 4'd8), 128'(1));
      @(negedge clk);
    end
    cp0_index = 4'd9;
    start_op(2'd0);
    finish_op();

    // Reset asserted during EXEC of a TLBWI.
    cp0_index = 4'd3;
    start_op(2'd1);
    chk("abort_we_before", 128'(tlbrw_we), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("abort_we_drop", 128'(tlbrw_we), 128'(0));
    chk("abort_op_ready", 128'(op_ready), 128'(1));
    chk("abort_resp_valid", 128'(resp_valid), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", 128'(resp_valid), 128'(0));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
- Initiator side of the MMU TLB maintenance port. Executes committed TLBR/TLBWI/TLBWR/TLBP instructions as a small FSM.
- Drives the MMU's tlbrw_index/tlbrw_we/tlbrw_wdata/tlbp_entry_hi and captures tlbrw_rdata/tlbp_index.
- Owns the CP0 Random counter and returns results for CP0 write-back.
- Sits between the commit stage / CP0 and the mmu block.

Parameters:
- TLB_ENTRIES, 16: number of TLB entries, power of two, 4..64.
- INDEX_WIDTH, $clog2(TLB_ENTRIES): width of entry index fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  TLB operation request
- op_ready  out  1  unit can accept request
- op_type  in  2  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP
- cp0_index  in  INDEX_WIDTH  CP0 Index field
- cp0_entry_hi  in  32  CP0 EntryHi (VPN2 [31:13], ASID [7:0])
- cp0_entry_lo0  in  32  CP0 EntryLo0 (PFN, C, D, V, G)
- cp0_entry_lo1  in  32  CP0 EntryLo1
- wired  in  INDEX_WIDTH  CP0 Wired value
- wired_we  in  1  CP0 Wired being written this cycle
- tlbrw_index  out  INDEX_WIDTH  to mmu
- tlbrw_we  out  1  to mmu
- tlbrw_wdata  out  tlb_entry_t  to mmu
- tlbrw_rdata  in  tlb_entry_t  from mmu
- tlbp_entry_hi  out  32  to mmu
- tlbp_index  in  32  from mmu (bit31 = probe miss, low bits = index)
- resp_valid  out  1  result available
- resp_ready  in  1  CP0 accepts result
- resp_type  out  2  op_type of completed op
- resp_index  out  32  TLBP result, Index register format
- resp_entry  out  tlb_entry_t  TLBR result
- random  out  INDEX_WIDTH  CP0 Random value

Behaviour:
- Reset (rst low, async):
  - state=IDLE; op_ready=1; resp_valid=0; tlbrw_we=0.
  - tlbrw_index=0; tlbrw_wdata=0; tlbp_entry_hi=0.
  - resp_type=0; resp_index=0; resp_entry=0; random=TLB_ENTRIES-1.
- FSM has three states: IDLE, EXEC, RESP.
  - IDLE: op_ready=1. On op_valid, latch op_type, cp0 inputs and the current random value, then go to EXEC.
  - EXEC: always exactly one cycle. Drives the MMU from the latched values, then goes to RESP.
  - RESP: resp_valid=1. Holds all resp_* stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
  - Back-to-back ops: earliest next acceptance is the cycle after the handshake. op_ready=0 in EXEC and RESP.
- Latency: accepted at cycle T, MMU access at T+1, resp_valid at T+2 (minimum 2 cycles).
- Entry packing for TLBWI/TLBWR:
  - vpn2, asid from EntryHi.
  - G = lo0.G & lo1.G.
  - pfn, c, d, v per page from lo0/lo1, using the tlb_entry_t field layout.
- TLBWI: in EXEC, tlbrw_index=latched cp0_index and tlbrw_we=1 for exactly one cycle.
- TLBWR: same as TLBWI, but tlbrw_index=latched random.
- TLBR: in EXEC, tlbrw_index=cp0_index and tlbrw_we=0. Capture tlbrw_rdata at the end of EXEC into resp_entry.
- TLBP: in EXEC, tlbp_entry_hi=latched EntryHi. Capture at the end of EXEC: resp_index = {tlbp_index[31], 31'b0 | tlbp_index[INDEX_WIDTH-1:0]}.
- resp_entry and resp_index are don't-care for op types that do not produce them; the bench checks them only for TLBR and TLBP respectively.
- tlbrw_we is never asserted outside EXEC. No TLB write occurs in any other state, including on reset.
- Random counter, every cycle:
  - wired_we=1: random <= TLB_ENTRIES-1. This has priority.
  - else if random <= wired, or wired >= TLB_ENTRIES-1: random <= TLB_ENTRIES-1 (wrap).
  - else: random <= random-1.
  - Range is [wired, TLB_ENTRIES-1]. It does not pause during ops; TLBWR uses the value latched at acceptance.
- Reset mid-operation: returns to IDLE immediately. tlbrw_we drops asynchronously and the pending op is discarded.

Test Plan:
- Reset: hold rst low for 3 cycles → random=15, op_ready=1, resp_valid=0, tlbrw_we=0. Release → random counts 15,14,…,0,15 with wired=0.
- TLBWI, cp0_index=5, EntryHi=0x12346_0A5 (asid 0xA5), lo0 G=1, lo1 G=0 → tlbrw_we=1 for one cycle at T+1 with index 5 and G=0. resp_valid at T+2, resp_type=1.
- TLBR of index 5 after the above write → resp_entry equals the written entry. resp_valid held for 3 cycles while resp_ready=0, with values stable.
- TLBP:
  - Hit on entry 5 → resp_index=0x00000005.
  - Unmatched ASID → resp_index bit31=1.
- Wired=8 written (wired_we) → random=15 next cycle, then decrements to 8, wraps to 15, never below 8. TLBWR issued when random=9 → tlbrw_index=9.
- Assert rst during EXEC of a TLBWI → tlbrw_we deasserts immediately, state=IDLE, no resp_valid.
